// File: rtl/updown_counter_if.sv
// Control and status bundle of one updown_counter_mod instance.
// The counter binds to the slave side; whoever drives the controls uses the master side.
interface updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             sclr;
  logic             pr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ce;
  logic             mode;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             zero;

  modport master (
    output sclr, pr, load, din, ce, mode, sat,
    input  count, tc, wrap, zero
  );

  modport slave (
    input  sclr, pr, load, din, ce, mode, sat,
    output count, tc, wrap, zero
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with wrap or saturate, prioritised clear/preset/load
// and cascade-ready terminal-count and wrap outputs.
module updown_counter_mod #(
  parameter int WIDTH = 4,
  parameter int MOD   = 2 ** WIDTH
) (
  input  logic               clk,
  input  logic               clr_n,
  updown_counter_if.slave    bus
);

  if (WIDTH < 1 || WIDTH > 16 || MOD < 2 || MOD > 2 ** WIDTH) begin : g_bad_param
    $error("updown_counter_mod: illegal WIDTH/MOD combination");
  end

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == ZERO_C);

  // Only the highest-priority action applies; range ends compare against MOD-1,
  // so nothing at or above MOD can ever be stored.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.sclr) begin
      count_d = ZERO_C;
    end else if (bus.pr) begin
      count_d = MAX_C;
    end else if (bus.load) begin
      count_d = (bus.din > MAX_C) ? MAX_C : bus.din;
    end else if (bus.ce) begin
      if (!bus.mode) begin
        if (!at_max) begin
          count_d = count_q + ONE_C;
        end else if (!bus.sat) begin
          count_d = ZERO_C;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - ONE_C;
        end else if (!bus.sat) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= ZERO_C;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count ignores sat so a cascaded digit still sees the end of range.
  assign bus.tc    = bus.ce & (bus.mode ? at_zero : at_max);
  assign bus.zero  = at_zero;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scenario bench for updown_counter_mod: decade counter, cascaded decade pair and a
// full-range 3-bit counter, with expected {wrap,count} pushed before each edge.
module tb_updown_counter_mod;

  logic clk;
  logic clr_n;

  updown_counter_if #(.WIDTH(4)) m_if ();
  updown_counter_if #(.WIDTH(4)) u_if ();
  updown_counter_if #(.WIDTH(4)) t_if ();
  updown_counter_if #(.WIDTH(3)) b_if ();

  updown_counter_mod #(.WIDTH(4), .MOD(10)) u_main  (.clk(clk), .clr_n(clr_n), .bus(m_if));
  updown_counter_mod #(.WIDTH(4), .MOD(10)) u_units (.clk(clk), .clr_n(clr_n), .bus(u_if));
  updown_counter_mod #(.WIDTH(4), .MOD(10)) u_tens  (.clk(clk), .clr_n(clr_n), .bus(t_if));
  updown_counter_mod #(.WIDTH(3), .MOD(8))  u_bin   (.clk(clk), .clr_n(clr_n), .bus(b_if));

  assign t_if.ce = u_if.tc;

  int vectors;
  int miscompares;
  logic [4:0] exp_q[$];
  logic [9:0] cas_q[$];
  logic [4:0] exp_v;
  logic [9:0] cas_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m_if.sclr = 0; m_if.pr = 0; m_if.load = 0; m_if.din = 0; m_if.ce = 0; m_if.mode = 0; m_if.sat = 0;
    u_if.sclr = 0; u_if.pr = 0; u_if.load = 0; u_if.din = 0; u_if.ce = 0; u_if.mode = 0; u_if.sat = 0;
    t_if.sclr = 0; t_if.pr = 0; t_if.load = 0; t_if.din = 0; t_if.mode = 0; t_if.sat = 0;
    b_if.sclr = 0; b_if.pr = 0; b_if.load = 0; b_if.din = 0; b_if.ce = 0; b_if.mode = 0; b_if.sat = 0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #1;
    vectors++;
    if (m_if.count !== 4'd0 || m_if.wrap !== 1'b0 || m_if.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_init: count=%0d wrap=%0b zero=%0b, want 0 0 1", m_if.count, m_if.wrap, m_if.zero);
    end
    @(negedge clk);
    clr_n = 1'b1;
    m_if.load = 1; m_if.din = 4'd7;
    exp_q.push_back({1'b0, 4'd7});
    clock_edge();
    exp_v = exp_q.pop_front();
    vectors++;
    if ({m_if.wrap, m_if.count} !== exp_v) begin
      miscompares++;
      $display("FAIL reset_load7: got %0h want %0h", {m_if.wrap, m_if.count}, exp_v);
    end
    m_if.load = 0;
    @(negedge clk);
    clr_n = 1'b0;
    m_if.ce = 1; m_if.mode = 1;
    #1;
    vectors++;
    if (m_if.count !== 4'd0 || m_if.wrap !== 1'b0 || m_if.tc !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: count=%0d wrap=%0b tc=%0b, want 0 0 1", m_if.count, m_if.wrap, m_if.tc);
    end
    m_if.mode = 0; m_if.load = 1; m_if.din = 4'd5;
    clock_edge();
    clock_edge();
    vectors++;
    if (m_if.count !== 4'd0 || m_if.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: count=%0d tc=%0b, want 0 0", m_if.count, m_if.tc);
    end
    // Pending wrap pulse must be killed by reset.
    @(negedge clk);
    clr_n = 1'b1;
    m_if.din = 4'd9; m_if.ce = 0;
    clock_edge();
    m_if.load = 0; m_if.ce = 1;
    clock_edge();
    vectors++;
    if (m_if.wrap !== 1'b1 || m_if.count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_prewrap: wrap=%0b count=%0d, want 1 0", m_if.wrap, m_if.count);
    end
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    vectors++;
    if (m_if.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_killwrap: wrap=%0b want 0", m_if.wrap);
    end
    @(negedge clk);
    clr_n = 1'b1;
    exp_q.push_back({1'b0, 4'd1});
    clock_edge();
    exp_v = exp_q.pop_front();
    vectors++;
    if ({m_if.wrap, m_if.count} !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release: got %0h want %0h", {m_if.wrap, m_if.count}, exp_v);
    end
    m_if.ce = 0;
  endtask

  task automatic test_decade_up();
    int cur;
    m_if.sclr = 1;
    clock_edge();
    m_if.sclr = 0; m_if.ce = 1; m_if.mode = 0; m_if.sat = 0;
    for (int i = 0; i < 12; i++) begin
      cur = i % 10;
      vectors++;
      if (m_if.tc !== (cur == 9)) begin
        miscompares++;
        $display("FAIL decade_tc[%0d]: tc=%0b want %0b", i, m_if.tc, (cur == 9));
      end
      exp_q.push_back({cur == 9, 4'((i + 1) % 10)});
      clock_edge();
      exp_v = exp_q.pop_front();
      vectors++;
      if ({m_if.wrap, m_if.count} !== exp_v) begin
        miscompares++;
        $display("FAIL decade_cnt[%0d]: got %0h want %0h", i, {m_if.wrap, m_if.count}, exp_v);
      end
    end
    m_if.ce = 0;
  endtask

  task automatic test_down_sat();
    logic [3:0] seq [4];
    logic [3:0] prev;
    seq[0] = 4'd1; seq[1] = 4'd0; seq[2] = 4'd0; seq[3] = 4'd0;
    m_if.load = 1; m_if.din = 4'd2;
    clock_edge();
    m_if.load = 0; m_if.ce = 1; m_if.mode = 1; m_if.sat = 1;
    prev = 4'd2;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (m_if.tc !== (prev == 0)) begin
        miscompares++;
        $display("FAIL downsat_tc[%0d]: tc=%0b want %0b", i, m_if.tc, (prev == 0));
      end
      exp_q.push_back({1'b0, seq[i]});
      clock_edge();
      exp_v = exp_q.pop_front();
      vectors++;
      if ({m_if.wrap, m_if.count} !== exp_v) begin
        miscompares++;
        $display("FAIL downsat_cnt[%0d]: got %0h want %0h", i, {m_if.wrap, m_if.count}, exp_v);
      end
      prev = seq[i];
    end
    m_if.sat = 0;
    exp_q.push_back({1'b1, 4'd9});
    m_if.ce = 1;
    clock_edge();
    m_if.ce = 0;
    exp_q.push_back({1'b0, 4'd9});
    clock_edge();
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      vectors++;
      if (i == 1 && {m_if.wrap, m_if.count} !== exp_v) begin
        miscompares++;
        $display("FAIL downwrap_hold: got %0h want %0h", {m_if.wrap, m_if.count}, exp_v);
      end
    end
    m_if.mode = 0;
  endtask

  task automatic test_priority();
    logic [4:0] ctl [6];    // {sclr,pr,load,ce,mode}
    logic [3:0] dins [6];
    logic [3:0] want [6];
    ctl[0] = 5'b11110; dins[0] = 4'd5;  want[0] = 4'd0;
    ctl[1] = 5'b01100; dins[1] = 4'd5;  want[1] = 4'd9;
    ctl[2] = 5'b00100; dins[2] = 4'd3;  want[2] = 4'd3;
    ctl[3] = 5'b00100; dins[3] = 4'd13; want[3] = 4'd9;
    ctl[4] = 5'b00100; dins[4] = 4'd4;  want[4] = 4'd4;
    ctl[5] = 5'b00111; dins[5] = 4'd15; want[5] = 4'd9;
    m_if.load = 1; m_if.din = 4'd7;
    clock_edge();
    for (int i = 0; i < 6; i++) begin
      {m_if.sclr, m_if.pr, m_if.load, m_if.ce, m_if.mode} = ctl[i];
      m_if.din = dins[i];
      exp_q.push_back({1'b0, want[i]});
      clock_edge();
      exp_v = exp_q.pop_front();
      vectors++;
      if ({m_if.wrap, m_if.count} !== exp_v) begin
        miscompares++;
        $display("FAIL prio[%0d]: got %0h want %0h", i, {m_if.wrap, m_if.count}, exp_v);
      end
    end
    {m_if.sclr, m_if.pr, m_if.load, m_if.ce, m_if.mode} = 5'b0;
  endtask

  task automatic test_cascade();
    u_if.sclr = 1; t_if.sclr = 1;
    clock_edge();
    u_if.sclr = 0; t_if.sclr = 0; u_if.ce = 1;
    for (int e = 1; e <= 100; e++) begin
      cas_q.push_back({e == 100, (e % 10) == 0, 4'((e / 10) % 10), 4'(e % 10)});
      clock_edge();
      cas_v = cas_q.pop_front();
      vectors++;
      if ({t_if.wrap, u_if.wrap, t_if.count, u_if.count} !== cas_v) begin
        miscompares++;
        $display("FAIL cascade[%0d]: got %0h want %0h", e, {t_if.wrap, u_if.wrap, t_if.count, u_if.count}, cas_v);
      end
    end
    u_if.ce = 0;
  endtask

  task automatic test_full_binary();
    b_if.load = 1; b_if.din = 3'd7;
    clock_edge();
    b_if.load = 0; b_if.ce = 1; b_if.sat = 0; b_if.mode = 0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({(i % 8) == 0, 1'b0, 3'((7 + i + 1) % 8)});
      clock_edge();
      exp_v = exp_q.pop_front();
      vectors++;
      if ({b_if.wrap, 1'b0, b_if.count} !== exp_v) begin
        miscompares++;
        $display("FAIL bin_up[%0d]: got %0h want %0h", i, {b_if.wrap, 1'b0, b_if.count}, exp_v);
      end
    end
    b_if.sclr = 1;
    clock_edge();
    b_if.sclr = 0; b_if.mode = 1;
    exp_q.push_back({1'b1, 1'b0, 3'd7});
    clock_edge();
    exp_v = exp_q.pop_front();
    vectors++;
    if ({b_if.wrap, 1'b0, b_if.count} !== exp_v) begin
      miscompares++;
      $display("FAIL bin_down_wrap: got %0h want %0h", {b_if.wrap, 1'b0, b_if.count}, exp_v);
    end
    b_if.ce = 0;
  endtask

  task automatic test_random();
    int mc;
    int nc;
    logic nw;
    m_if.sclr = 1;
    clock_edge();
    mc = 0;
    for (int i = 0; i < 300; i++) begin
      m_if.sclr = ($urandom_range(0, 15) == 0);
      m_if.pr   = ($urandom_range(0, 15) == 0);
      m_if.load = ($urandom_range(0, 7) == 0);
      m_if.din  = 4'($urandom_range(0, 15));
      m_if.ce   = ($urandom_range(0, 3) != 0);
      m_if.mode = 1'($urandom_range(0, 1));
      m_if.sat  = ($urandom_range(0, 3) == 0);
      #1;
      vectors++;
      if (m_if.tc !== (m_if.ce && (m_if.mode ? (mc == 0) : (mc == 9))) || m_if.zero !== (mc == 0)) begin
        miscompares++;
        $display("FAIL rand_comb[%0d]: tc=%0b zero=%0b model_count=%0d", i, m_if.tc, m_if.zero, mc);
      end
      nw = 1'b0;
      nc = mc;
      if (m_if.sclr) nc = 0;
      else if (m_if.pr) nc = 9;
      else if (m_if.load) nc = (m_if.din > 9) ? 9 : int'(m_if.din);
      else if (m_if.ce && !m_if.mode) begin
        if (mc < 9) nc = mc + 1;
        else if (!m_if.sat) begin nc = 0; nw = 1'b1; end
      end else if (m_if.ce && m_if.mode) begin
        if (mc > 0) nc = mc - 1;
        else if (!m_if.sat) begin nc = 9; nw = 1'b1; end
      end
      exp_q.push_back({nw, 4'(nc)});
      mc = nc;
      clock_edge();
      exp_v = exp_q.pop_front();
      vectors++;
      if ({m_if.wrap, m_if.count} !== exp_v) begin
        miscompares++;
        $display("FAIL rand_cnt[%0d]: got %0h want %0h", i, {m_if.wrap, m_if.count}, exp_v);
      end
    end
    m_if.sclr = 0; m_if.pr = 0; m_if.load = 0; m_if.ce = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clr_n = 1'b0;
    idle_all();
    test_reset();
    test_decade_up();
    test_down_sat();
    test_priority();
    test_cascade();
    test_full_binary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter: the general-purpose counter for the lab designs. It replaces the fixed 4-bit wrap-only counter with:
- configurable width and modulus;
- wrap or saturate behaviour;
- prioritised synchronous clear, preset and load;
- cascade-ready terminal-count and wrap outputs.

It sits under timers, BCD digit chains and display scanners. Several instances chain through `tc` to `ce`.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits, 1 to 16.
- `MOD`, 2**WIDTH: modulus. Count range is 0..MOD-1. Legal range is 2 ≤ MOD ≤ 2**WIDTH.

Ports:
- `clk` input 1: the only clock. Rising edge active.
- `clr_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `sclr` input 1: synchronous clear to 0.
- `pr` input 1: synchronous preset to MOD-1.
- `load` input 1: synchronous load of `din`.
- `din` input WIDTH: load value.
- `ce` input 1: count enable.
- `mode` input 1: direction. 0 = up, 1 = down.
- `sat` input 1: end-of-range behaviour. 0 = wrap, 1 = saturate at the range end.
- `count` output WIDTH: current count, registered.
- `tc` output 1: terminal count, combinational. High when `ce` is high and the count sits at the end of range for the current direction.
- `wrap` output 1: registered. One-cycle pulse after a wrap occurred.
- `zero` output 1: combinational. `count == 0`.

## Operation
- Priority per rising edge, highest first: `clr_n` (async), `sclr`, `pr`, `load`, `ce`. Only the highest active action applies.
- `sclr`: count ← 0.
- `pr`: count ← MOD-1.
- `load`: count ← `din` if `din` ≤ MOD-1. Otherwise count ← MOD-1 (clamped). `load` acts regardless of `ce`.
- `ce`=1, `mode`=0 (up):
  - count < MOD-1: count ← count+1.
  - count == MOD-1, `sat`=0: count ← 0 and `wrap` is asserted.
  - count == MOD-1, `sat`=1: count holds; no `wrap`.
- `ce`=1, `mode`=1 (down):
  - count > 0: count ← count-1.
  - count == 0, `sat`=0: count ← MOD-1 and `wrap` is asserted.
  - count == 0, `sat`=1: count holds; no `wrap`.
- `ce`=0 with no higher action: count holds.
- `tc` = `ce` & (`mode` ? count==0 : count==MOD-1). It is independent of `sat`. Cascade rule: a higher digit's `ce` = lower digit's `tc`.
- `wrap` is high for exactly the cycle after the wrapping edge. It is 0 after any `sclr`/`pr`/`load` edge or in hold.
- Arithmetic is WIDTH bits. Next-state compare uses MOD-1, not 2**WIDTH-1, so no intermediate value ≥ MOD ever reaches `count`.
- `mode` or `sat` may change on any cycle. Each edge uses the values sampled at that edge.

## Timing
- Reset (`clr_n`=0): `count`=0 and `wrap`=0 immediately, without waiting for a clock. Derived values: `zero`=1; `tc` = `ce` & `mode`.
- While `clr_n`=0, all synchronous inputs are ignored.
- Release of `clr_n` is a plain level. The first update happens at the first rising edge with `clr_n`=1.
- Assertion of `clr_n` mid-count aborts the count with no partial state. It also clears any pending `wrap` pulse.
- Latency:
  - control inputs to `count`: 1 clock.
  - `count`/`ce`/`mode` to `tc`/`zero`: combinational, same cycle.
  - wrapping edge to `wrap`: visible for the following cycle only.
- No multicycle paths. The `tc`→`ce` cascade through N instances forms a combinational chain of N AND stages in one cycle.

## Test plan
- **Reset:** WIDTH=4, MOD=10, count at 7. Drop `clr_n` between edges. Required: `count`=0 and `wrap`=0 before the next edge, and 0 is held across edges while low. Release: counting resumes 0→1 on the first edge.
- **Decade wrap up:** MOD=10, `ce`=1, `mode`=0, `sat`=0, 12 edges from 0. Required sequence: 1..9,0,1,2. `tc`=1 only while count=9. `wrap`=1 for exactly the cycle count=0 after 9.
- **Down and saturate:** MOD=10, count at 2, `mode`=1.
  - `sat`=1, 4 edges: required 1,0,0,0, with no `wrap` and `tc`=1 while at 0.
  - `sat`=0, one more edge: required count=9 and `wrap` pulse.
- **Priority and clamp:**
  - `sclr`, `pr`, `load` and `ce` all high on one edge: required count=0.
  - Then `pr`+`load`: required 9.
  - Then `load` alone with `din`=13: required 9 (clamped).
  - Then `load` with `din`=4 and `ce`=0: required 4.
- **Cascade:** two instances, MOD=10, with units `tc` driving tens `ce`, counting up from 00 for 100 edges.
  - Required: tens increments only on units 9→0; the display reads 99 at edge 99 and 00 at edge 100.
  - Both `wrap` outputs pulse at edge 100.
- **Full binary range:** WIDTH=3, MOD=8, up from 7 with `sat`=0. Required: 0 with `wrap`. `count` never exceeds 7.
